// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format defaults, FSM state encoding and
// counter sizing helpers used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int NB_DATA_BITS_DEF = 8;
  localparam int OVERSAMPLE_DEF   = 16;
  localparam int SB_TICK_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA_BITS data bits LSB first, one stop bit,
// all timed in baud_tick pulses.
//
// state | meaning
// IDLE  | line high, waiting for tx_start
// START | driving start bit (0) for OVERSAMPLE ticks
// DATA  | driving shift register bit 0, one bit per OVERSAMPLE ticks
// STOP  | driving stop bit (1) for SB_TICK ticks, tx_done on exit
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA_BITS = NB_DATA_BITS_DEF,
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int SB_TICK      = SB_TICK_DEF
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    baud_tick,
  input  logic [NB_DATA_BITS-1:0] tx_data_in,
  input  logic                    tx_start,
  output logic                    tx,
  output logic                    tx_busy,
  output logic                    tx_done
);

  localparam int TICK_W = cnt_width(max_int(OVERSAMPLE, SB_TICK));
  localparam int BIT_W  = cnt_width(NB_DATA_BITS);

  localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(NB_DATA_BITS - 1);

  uart_state_e              state_q, state_d;
  logic [TICK_W-1:0]        tick_q, tick_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [NB_DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                     tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    tx_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shreg_d = tx_data_in;
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            tx_d    = shreg_q[0];
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
              tx_d  = shreg_d[0];
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (tick_q == SB_LAST) begin
            tick_d  = '0;
            state_d = ST_IDLE;
            // Suppressed when reset lands on the final stop tick: the frame is aborted.
            tx_done = i_rst;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: the line is predicted from the number of
// baud ticks consumed since the accepting edge.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int NB    = NB_DATA_BITS_DEF;
  localparam int OS    = OVERSAMPLE_DEF;
  localparam int SB    = SB_TICK_DEF;
  localparam int FRAME = (1 + NB) * OS + SB;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          baud_tick = 1'b0;
  logic          tx_start = 1'b0;
  logic [NB-1:0] tx_data_in = '0;
  logic          tx, tx_busy, tx_done;

  int errors = 0;
  int checks = 0;
  int tick_div = 0;

  uart_tx #(.NB_DATA_BITS(NB), .OVERSAMPLE(OS), .SB_TICK(SB)) dut (
    .clk(clk), .i_rst(i_rst), .baud_tick(baud_tick), .tx_data_in(tx_data_in),
    .tx_start(tx_start), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Line level after n ticks of a frame: start bit, data LSB first, then stop/idle.
  function automatic logic exp_line(input logic [NB-1:0] d, input int n);
    if (n < OS) return 1'b0;
    else if (n < (1 + NB) * OS) return d[n / OS - 1];
    else return 1'b1;
  endfunction

  function automatic logic pick_tick();
    if (tick_div == 0) return 1'b1;
    return ($urandom_range(tick_div - 1, 0) == 0);
  endfunction

  // start_mode: 0 random tx_start during frame, 1 held high, 2 high only in
  // the tx_done cycle, 3 low. Modes 1/2 must be followed by another frame.
  task automatic check_frame(input logic [NB-1:0] data, input int start_mode,
                             input string name, output int done_at);
    int n, cyc, budget;
    logic exp_done;
    budget = (tick_div == 0) ? FRAME + 4 : FRAME * tick_div * 6 + 50;
    tx_data_in = data;
    tx_start   = 1'b1;
    baud_tick  = pick_tick();
    n = 0; cyc = 0; done_at = -1;
    while (n < FRAME) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== exp_line(data, n)) begin
        errors++;
        $display("FAIL %s tx at tick %0d: got %b expected %b", name, n, tx, exp_line(data, n));
      end
      checks++;
      if (tx_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy at tick %0d: got %b expected 1", name, n, tx_busy);
      end
      baud_tick  = pick_tick();
      tx_data_in = NB'($urandom);
      case (start_mode)
        0: tx_start = 1'($urandom_range(1, 0));
        1: tx_start = 1'b1;
        2: tx_start = baud_tick && (n == FRAME - 1);
        default: tx_start = 1'b0;
      endcase
      #1;
      exp_done = baud_tick && (n == FRAME - 1);
      checks++;
      if (tx_done !== exp_done) begin
        errors++;
        $display("FAIL %s done at tick %0d: got %b expected %b", name, n, tx_done, exp_done);
      end
      if (tx_done === 1'b1) done_at = cyc;
      if (baud_tick) n++;
      cyc++;
      if (cyc > budget) begin
        errors++;
        $display("FAIL %s timeout: got %0d ticks expected %0d", name, n, FRAME);
        break;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle gap: got tx=%b busy=%b expected tx=1 busy=0", name, tx, tx_busy);
    end
    if (start_mode == 0 || start_mode == 3) tx_start = 1'b0;
    baud_tick = pick_tick();
    #1;
    checks++;
    if (tx_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done in idle: got %b expected 0", name, tx_done);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0; tx_start = 1'b1; baud_tick = 1'b1; tx_data_in = NB'($urandom);
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL reset: got tx=%b busy=%b done=%b expected 1 0 0", tx, tx_busy, tx_done);
      end
    end
    i_rst = 1'b1; tx_start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL idle after reset: got tx=%b busy=%b done=%b expected 1 0 0", tx, tx_busy, tx_done);
      end
    end
  endtask

  task automatic test_full_rate();
    int d;
    tick_div = 0;
    check_frame(8'h81, 3, "full_rate_81", d);
    checks++;
    if (d !== FRAME - 1) begin
      errors++;
      $display("FAIL done_latency: got cycle %0d expected %0d", d, FRAME - 1);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    tick_div = 2;
    check_frame(8'hA5, 1, "b2b_A5", d);
    check_frame(8'h3C, 3, "b2b_3C", d);
  endtask

  task automatic test_start_in_done();
    int d;
    tick_div = 2;
    check_frame(NB'($urandom), 2, "done_cycle_start", d);
    check_frame(NB'($urandom), 3, "after_done_start", d);
  endtask

  task automatic test_reset_midframe();
    int d;
    tick_div = 0;
    tx_data_in = 8'hFF; tx_start = 1'b1; baud_tick = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (4 * OS + 6) @(posedge clk);
    #1;
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe busy before reset: got %b expected 1", tx_busy);
    end
    i_rst = 1'b0; tx_start = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL midframe reset: got tx=%b busy=%b done=%b expected 1 0 0", tx, tx_busy, tx_done);
      end
    end
    i_rst = 1'b1; tx_start = 1'b0;
    repeat (2 * OS) begin
      @(posedge clk); #1;
      checks++;
      if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL post-reset idle: got busy=%b done=%b expected 0 0", tx_busy, tx_done);
      end
    end
    check_frame(8'h00, 3, "after_reset_00", d);
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 4; i++) begin
      tick_div = $urandom_range(3, 0);
      check_frame(NB'($urandom), 0, "random", d);
    end
  endtask

  initial begin
    int d;
    test_reset();
    tick_div = 2;
    check_frame(8'h55, 3, "pattern_55", d);
    test_full_rate();
    tick_div = 3;
    check_frame(8'hF0, 0, "ignore_start_F0", d);
    test_back_to_back();
    test_start_in_done();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
